// File: rtl/digit_scan_ctrl.sv
// ----------------------------------------------------------------------------
// digit_scan_ctrl
//   Time-multiplexes a 4-digit display and drives the 2-to-4 enable/polarity
//   decoder (select w_out, polarity s_out, active-low enable en_n_out). It also
//   presents the active digit's nibble to the segment stage. An internal
//   prescaler sets the slot length. All outputs are registered and change only
//   at slot boundaries, when scanning stops, or on reset.
//
//   Optional feature macro: SCAN_BLANK_EN
//     When it is defined, every slot is followed by BLANK_CYC cycles with the
//     decoder disabled. This suppresses ghosting between digits.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous reset, active-low
//   run          in   1   1 = scan, 0 = idle/blank
//   polarity_in  in   1   digit-select polarity, sampled at slot entry
//   digit_mask   in   4   bit i = 1 lights digit i, sampled at slot entry
//   data_in      in   16  nibble i = data_in[4i+3:4i], sampled at slot entry
//   w_out        out  2   digit index to decoder w
//   s_out        out  1   polarity to decoder S
//   en_n_out     out  1   decoder enable (0 = drive a digit, 1 = all off)
//   nibble_out   out  4   nibble for the current digit
//   frame_done   out  1   one-cycle pulse on the first cycle after slot 3
// ----------------------------------------------------------------------------
module digit_scan_ctrl #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_MAX   = 49999,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        polarity_in,
    input  logic [3:0]  digit_mask,
    input  logic [15:0] data_in,
    output logic [1:0]  w_out,
    output logic        s_out,
    output logic        en_n_out,
    output logic [3:0]  nibble_out,
    output logic        frame_done
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);
`else
    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;
`endif

    localparam logic [DIV_W-1:0] SLOT_LAST = DIV_W'(DIV_MAX);

    // Elaboration-time parameter sanity checks.
    if (DIV_MAX >= (64'd1 << DIV_W)) begin : g_bad_div
        $error("digit_scan_ctrl: DIV_MAX does not fit in DIV_W bits");
    end
    if (BLANK_CYC < 1) begin : g_bad_blank
        $error("digit_scan_ctrl: BLANK_CYC must be at least 1");
    end

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       w_q, w_d;
    logic             s_q, s_d;
    logic             en_n_q, en_n_d;
    logic [3:0]       nib_q, nib_d;
    logic             fd_q, fd_d;

    // Slot-entry request and the digit index being entered.
    logic             entry;
    logic [1:0]       entry_w;
    logic [1:0]       w_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        s_d     = s_q;
        en_n_d  = en_n_q;
        nib_d   = nib_q;
        fd_d    = 1'b0;
        entry   = 1'b0;
        entry_w = 2'd0;
        w_next  = w_q + 2'd1;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                w_d    = 2'd0;
                en_n_d = 1'b1;
                if (run) begin
                    state_d = SHOW;
                    entry   = 1'b1;
                    entry_w = 2'd0;
                end
            end
            SHOW: begin
                if (!run) begin
                    // Stopping the scan takes priority over a slot end.
                    state_d = IDLE;
                    cnt_d   = '0;
                    w_d     = 2'd0;
                    en_n_d  = 1'b1;
                end else if (cnt_q == SLOT_LAST) begin
`ifdef SCAN_BLANK_EN
                    state_d = BLANK;
                    cnt_d   = '0;
                    en_n_d  = 1'b1;
`else
                    entry   = 1'b1;
                    entry_w = w_next;
                    fd_d    = (w_q == 2'd3);
`endif
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    w_d     = 2'd0;
                    en_n_d  = 1'b1;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    entry   = 1'b1;
                    entry_w = w_next;
                    fd_d    = (w_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                w_d     = 2'd0;
                en_n_d  = 1'b1;
            end
`endif
        endcase

        // Slot entry: this is the only point where the slot inputs are sampled.
        if (entry) begin
            w_d    = entry_w;
            s_d    = polarity_in;
            en_n_d = ~digit_mask[entry_w];
            nib_d  = data_in[{entry_w, 2'b00} +: 4];
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= 2'd0;
            s_q     <= 1'b1;
            en_n_q  <= 1'b1;
            nib_q   <= 4'd0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            s_q     <= s_d;
            en_n_q  <= en_n_d;
            nib_q   <= nib_d;
            fd_q    <= fd_d;
        end
    end

    assign w_out      = w_q;
    assign s_out      = s_q;
    assign en_n_out   = en_n_q;
    assign nibble_out = nib_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_digit_scan_ctrl
//   Directed self-checking bench for digit_scan_ctrl with DIV_MAX=3 (4-cycle
//   slots) and BLANK_CYC=2. When SCAN_BLANK_EN is defined, each slot is
//   followed by two blank cycles.
// ----------------------------------------------------------------------------
module tb_digit_scan_ctrl;

`ifdef SCAN_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif
    localparam int SL = 4 + BL;     // cycles per slot including the blank
    localparam int FR = 4 * SL;     // frame period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        polarity_in;
    logic [3:0]  digit_mask;
    logic [15:0] data_in;
    logic [1:0]  w_out;
    logic        s_out;
    logic        en_n_out;
    logic [3:0]  nibble_out;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    digit_scan_ctrl #(
        .DIV_W    (4),
        .DIV_MAX  (3),
        .BLANK_CYC(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .polarity_in(polarity_in),
        .digit_mask (digit_mask),
        .data_in    (data_in),
        .w_out      (w_out),
        .s_out      (s_out),
        .en_n_out   (en_n_out),
        .nibble_out (nibble_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".en_n"}, 0, 16'(en_n_out), 16'd1);
        chk({tag, ".w"}, 0, 16'(w_out), 16'd0);
        chk({tag, ".fd"}, 0, 16'(frame_done), 16'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".w"}, 0, 16'(w_out), 16'd0);
        chk({tag, ".s"}, 0, 16'(s_out), 16'd1);
        chk({tag, ".en_n"}, 0, 16'(en_n_out), 16'd1);
        chk({tag, ".nib"}, 0, 16'(nibble_out), 16'd0);
        chk({tag, ".fd"}, 0, 16'(frame_done), 16'd0);
    endtask

    // Cycle k counts the edges since run was first seen in IDLE (k=1 is the
    // first cycle of slot 0). After the checks of cycle chg_k, the polarity
    // and data switch to p1/d1. Only slots entered later may show the change.
    task automatic run_check(input string tag, input int ncyc, input logic [3:0] m,
                             input logic p0, input logic [15:0] d0,
                             input int chg_k, input logic p1, input logic [15:0] d1);
        int          p, slot, off, e;
        logic        ps;
        logic [15:0] ds;
        logic        exp_en;
        digit_mask  = m;
        polarity_in = p0;
        data_in     = d0;
        run         = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            p    = (k - 1) % FR;
            slot = p / SL;
            off  = p % SL;
            e    = k - off;
            ps   = (e > chg_k) ? p1 : p0;
            ds   = (e > chg_k) ? d1 : d0;
            exp_en = (off < 4) ? ~m[slot] : 1'b1;
            chk({tag, ".w"}, k, 16'(w_out), 16'(slot));
            chk({tag, ".en_n"}, k, 16'(en_n_out), 16'(exp_en));
            chk({tag, ".nib"}, k, 16'(nibble_out), 16'(ds[slot*4 +: 4]));
            chk({tag, ".s"}, k, 16'(s_out), 16'(ps));
            chk({tag, ".fd"}, k, 16'(frame_done), 16'((p == 0 && k > 1) ? 1 : 0));
            if (k == chg_k) begin
                polarity_in = p1;
                data_in     = d1;
            end
        end
    endtask

    initial begin
        // Reset held for two edges while run is high.
        rst_n       = 1'b0;
        run         = 1'b1;
        polarity_in = 1'b0;
        digit_mask  = 4'hF;
        data_in     = 16'hA5C3;
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;

        // Basic scan: two full frames plus a few cycles.
        run_check("scan", 2 * FR + 2, 4'b1111, 1'b1, 16'hA5C3, 1000, 1'b1, 16'hA5C3);
        run = 1'b0;
        tick();
        chk_idle("stop1");

        // Masked digits keep their slot time.
        run_check("mask", FR + 2, 4'b1010, 1'b1, 16'hA5C3, 1000, 1'b1, 16'hA5C3);
        run = 1'b0;
        tick();
        chk_idle("stop2");

        // All digits masked: enable stays off, frames continue.
        run_check("mask0", 2 * FR + 1, 4'b0000, 1'b1, 16'h9876, 1000, 1'b1, 16'h9876);
        run = 1'b0;
        tick();
        chk_idle("stop3");

        // Polarity and data change in the 2nd cycle of slot 1. Abort in the 3rd cycle of slot 2.
        run_check("pol", 2 * SL + 3, 4'b1111, 1'b1, 16'hA5C3, SL + 2, 1'b0, 16'h1234);
        run = 1'b0;
        tick();
        chk_idle("abort");
        tick();
        chk_idle("abort_hold");

        // A restart begins a full slot 0 and a whole frame.
        run_check("restart", FR + 1, 4'b1111, 1'b0, 16'h1234, 1000, 1'b0, 16'h1234);
        run = 1'b0;
        tick();
        chk_idle("stop4");

        // Stopping on the edge that ends slot 3 suppresses frame_done.
        run_check("edge", 3 * SL + 4, 4'b0110, 1'b1, 16'hBEEF, 1000, 1'b1, 16'hBEEF);
        run = 1'b0;
        tick();
        chk_idle("stop_at_end");

        // Reset mid-slot aborts the scan and restores the reset values.
        run_check("prerst", 6, 4'b1111, 1'b0, 16'h7777, 1000, 1'b0, 16'h7777);
        rst_n = 1'b0;
        tick();
        chk_reset("midreset");
        rst_n = 1'b1;
        run   = 1'b0;
        tick();
        chk_idle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
